// File: rtl/cnn_layer_accel_pkg.sv
// Shared types and constants for the CE weight-table sequencing logic.
package cnn_layer_accel_pkg;
  typedef enum logic [1:0] {IDLE, CFG, EXEC, DRAIN} wht_seq_state_t;
  localparam int KERNEL_SLOTS = 9;
  localparam logic [3:0] DUMMY_WHT_SLOT = 4'd9;
endpackage

// File: rtl/cnn_layer_accel_wht_cfg_loader.sv
// CFG-phase weight stream loader: slot/bubble/kernel counting and the
// registered table write port.
module cnn_layer_accel_wht_cfg_loader
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_KERNEL_SIZE = KERNEL_SLOTS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_active,
  input  logic [5:0]  i_kernel_last,
  input  logic        i_valid,
  input  logic [15:0] i_data,
  output logic        o_ready,
  output logic        o_wren,
  output logic [15:0] o_data,
  output logic        o_cfg_done
);
  logic [3:0]  r_slot;
  logic        r_bubble;
  logic [5:0]  r_kern;
  logic        r_wren;
  logic [15:0] r_data;
  logic        w_accept;

  assign o_ready    = i_active & ~r_bubble;
  assign w_accept   = o_ready & i_valid;
  assign o_cfg_done = i_active & r_bubble & (r_kern == i_kernel_last);
  assign o_wren     = r_wren;
  assign o_data     = r_data;

  // The bubble after each 9th write lines up with the table's count==9 wrap.
  always_ff @(posedge clk) begin
    if (rst || !i_active) begin
      r_slot   <= '0;
      r_bubble <= 1'b0;
      r_kern   <= '0;
    end else if (r_bubble) begin
      r_bubble <= 1'b0;
      r_kern   <= r_kern + 6'd1;
    end else if (w_accept) begin
      if (r_slot == 4'(C_KERNEL_SIZE - 1)) begin
        r_slot   <= '0;
        r_bubble <= 1'b1;
      end else begin
        r_slot <= r_slot + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wren <= 1'b0;
      r_data <= '0;
    end else begin
      r_wren <= w_accept;
      if (w_accept) r_data <= i_data;
    end
  end
endmodule

// File: rtl/cnn_layer_accel_wht_seq_ctrl.sv
// Job-level weight-table sequencer: kernel load in CFG, paired weight-address
// issue in EXEC, then a fixed drain before job_done.
module cnn_layer_accel_wht_seq_ctrl
  import cnn_layer_accel_pkg::*;
#(
  parameter int C_KERNEL_SIZE    = KERNEL_SLOTS,
  parameter int C_CYCLES_PER_PIX = 5,
  parameter int C_DRAIN_CYCLES   = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        job_start,
  input  logic [15:0] job_kernel_last,
  input  logic [15:0] job_pix_count,
  input  logic [2:0]  job_stride,
  input  logic        wht_in_valid,
  input  logic [15:0] wht_in_data,
  output logic        wht_in_ready,
  input  logic        ce_stall,
  output logic        config_mode,
  output logic        job_accept,
  output logic        kernel_config_valid,
  output logic [15:0] kernel_full_count,
  output logic        wht_config_wren,
  output logic [15:0] wht_config_data,
  output logic [3:0]  wht_seq_addr0,
  output logic [3:0]  wht_seq_addr1,
  output logic        ce_execute,
  output logic [2:0]  ce_cycle_counter,
  output logic [2:0]  output_stride,
  output logic        next_kernel,
  output logic        job_done
);
  wht_seq_state_t r_state, w_state_nxt;

  logic [15:0] r_kfull, r_pix_last, r_pix;
  logic [2:0]  r_stride, r_c, r_drain, r_cc;
  logic [5:0]  r_kern;
  logic [3:0]  r_addr0, r_addr1;
  logic        r_exec, r_nk_p0, r_nk_p1, r_done;
  logic        w_accept, w_cfg_done, w_issue, w_pix_end, w_kern_end, w_job_end, w_drain_end;
  logic [3:0]  w_odd_slot;

  cnn_layer_accel_wht_cfg_loader #(.C_KERNEL_SIZE(C_KERNEL_SIZE)) u_loader (
    .clk           (clk),
    .rst           (rst),
    .i_active      (r_state == CFG),
    .i_kernel_last (r_kfull[5:0]),
    .i_valid       (wht_in_valid),
    .i_data        (wht_in_data),
    .o_ready       (wht_in_ready),
    .o_wren        (wht_config_wren),
    .o_data        (wht_config_data),
    .o_cfg_done    (w_cfg_done)
  );

  assign w_issue     = (r_state == EXEC) & ~ce_stall;
  assign w_pix_end   = w_issue & (r_c == 3'(C_CYCLES_PER_PIX - 1));
  assign w_kern_end  = w_pix_end & (r_pix == r_pix_last);
  assign w_job_end   = w_kern_end & (r_kern == r_kfull[5:0]);
  assign w_drain_end = (r_state == DRAIN) & (r_drain == 3'(C_DRAIN_CYCLES - 1));
  assign w_odd_slot  = {r_c, 1'b1};

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    config_mode = 1'b0;
    case (r_state)
      IDLE: begin
        w_accept = job_start;
        if (job_start) w_state_nxt = CFG;
      end
      CFG: begin
        config_mode = 1'b1;
        if (w_cfg_done) w_state_nxt = EXEC;
      end
      EXEC:    if (w_job_end) w_state_nxt = DRAIN;
      DRAIN:   if (w_drain_end) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign job_accept          = w_accept;
  assign kernel_config_valid = w_accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_kfull    <= '0;
      r_stride   <= '0;
      r_pix_last <= '0;
    end else if (w_accept) begin
      r_kfull    <= job_kernel_last;
      r_stride   <= job_stride;
      r_pix_last <= (job_pix_count == 16'd0) ? 16'd0 : job_pix_count - 16'd1;
    end
  end

  // Issue counters restart at zero on every EXEC entry; a stall freezes them.
  always_ff @(posedge clk) begin
    if (rst || r_state != EXEC) begin
      r_c    <= '0;
      r_pix  <= '0;
      r_kern <= '0;
    end else if (w_issue) begin
      if (w_pix_end) begin
        r_c <= '0;
        if (w_kern_end) begin
          r_pix  <= '0;
          r_kern <= r_kern + 6'd1;
        end else begin
          r_pix <= r_pix + 16'd1;
        end
      end else begin
        r_c <= r_c + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_exec  <= 1'b0;
      r_cc    <= '0;
      r_addr0 <= '0;
      r_addr1 <= '0;
      r_nk_p0 <= 1'b0;
      r_nk_p1 <= 1'b0;
      r_done  <= 1'b0;
      r_drain <= '0;
    end else begin
      r_exec  <= w_issue;
      r_nk_p0 <= w_kern_end & ~w_job_end;
      r_nk_p1 <= r_nk_p0;
      r_done  <= w_drain_end;
      r_drain <= (r_state == DRAIN) ? r_drain + 3'd1 : 3'd0;
      if (w_issue) begin
        r_cc    <= r_c;
        r_addr0 <= {r_c, 1'b0};
        r_addr1 <= (w_odd_slot >= 4'(C_KERNEL_SIZE)) ? DUMMY_WHT_SLOT : w_odd_slot;
      end
    end
  end

  assign kernel_full_count = r_kfull;
  assign output_stride     = r_stride;
  assign ce_execute        = r_exec;
  assign ce_cycle_counter  = r_cc;
  assign wht_seq_addr0     = r_addr0;
  assign wht_seq_addr1     = r_addr1;
  assign next_kernel       = r_nk_p1;
  assign job_done          = r_done;
endmodule

// File: tb/tb_cnn_layer_accel_wht_seq_ctrl.sv
// Randomized scenario bench for the weight-table job sequencer.
module tb_cnn_layer_accel_wht_seq_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        job_start = 1'b0;
  logic [15:0] job_kernel_last = '0;
  logic [15:0] job_pix_count = '0;
  logic [2:0]  job_stride = '0;
  logic        wht_in_valid = 1'b0;
  logic [15:0] wht_in_data = '0;
  logic        wht_in_ready;
  logic        ce_stall = 1'b0;
  logic        config_mode, job_accept, kernel_config_valid;
  logic [15:0] kernel_full_count;
  logic        wht_config_wren;
  logic [15:0] wht_config_data;
  logic [3:0]  wht_seq_addr0, wht_seq_addr1;
  logic        ce_execute;
  logic [2:0]  ce_cycle_counter, output_stride;
  logic        next_kernel, job_done;

  int tests = 0;
  int fails = 0;

  // Results of the most recent run_job, checked by the scenario tasks.
  int r_wr, r_bub, r_iss, r_gap, done_cyc, last_iss_cyc, left_q;
  int nk_at[$];

  cnn_layer_accel_wht_seq_ctrl dut (
    .clk(clk), .rst(rst), .job_start(job_start), .job_kernel_last(job_kernel_last),
    .job_pix_count(job_pix_count), .job_stride(job_stride), .wht_in_valid(wht_in_valid),
    .wht_in_data(wht_in_data), .wht_in_ready(wht_in_ready), .ce_stall(ce_stall),
    .config_mode(config_mode), .job_accept(job_accept), .kernel_config_valid(kernel_config_valid),
    .kernel_full_count(kernel_full_count), .wht_config_wren(wht_config_wren),
    .wht_config_data(wht_config_data), .wht_seq_addr0(wht_seq_addr0), .wht_seq_addr1(wht_seq_addr1),
    .ce_execute(ce_execute), .ce_cycle_counter(ce_cycle_counter), .output_stride(output_stride),
    .next_kernel(next_kernel), .job_done(job_done)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] all_outs();
    return 64'({config_mode, job_accept, kernel_config_valid, kernel_full_count, wht_in_ready,
                wht_config_wren, wht_config_data, wht_seq_addr0, wht_seq_addr1, ce_execute,
                ce_cycle_counter, output_stride, next_kernel, job_done});
  endfunction

  // Runs one job and checks the stream/issue sequence inline; totals are left in r_*.
  task automatic run_job(input int k, input int pix, input bit rnd_valid,
                         input bit do_stall, input bit poke);
    logic [15:0] exp_q[$];
    logic [2:0]  stride;
    int c, e0, e1, stall_left;
    bit stalled, poked_cfg, poked_exec;
    r_wr = 0; r_bub = 0; r_iss = 0; r_gap = 0; done_cyc = -1; last_iss_cyc = -1;
    nk_at.delete();
    stall_left = 0; stalled = 0; poked_cfg = 0; poked_exec = 0;
    stride = 3'($urandom);
    @(negedge clk);
    job_kernel_last = 16'(k); job_pix_count = 16'(pix); job_stride = stride; job_start = 1'b1;
    #1;
    tests++;
    if (job_accept !== 1'b1 || kernel_config_valid !== 1'b1) begin
      fails++; $display("FAIL accept_pulse: got %0b/%0b want 1/1", job_accept, kernel_config_valid);
    end
    for (int cyc = 0; cyc < 3000 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      job_start = 1'b0; job_kernel_last = 16'(k);
      if (cyc == 0) begin
        tests++;
        if (kernel_full_count !== 16'(k) || output_stride !== stride || config_mode !== 1'b1) begin
          fails++; $display("FAIL job_regs: got k=%0d s=%0d cm=%0b want k=%0d s=%0d cm=1",
                            kernel_full_count, output_stride, config_mode, k, stride);
        end
      end
      if (wht_config_wren === 1'b1) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++; $display("FAIL wr_data: got unexpected write %0h want none", wht_config_data);
        end else begin
          if (wht_config_data !== exp_q[0]) begin
            fails++; $display("FAIL wr_data: got %0h want %0h", wht_config_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
        end
        r_wr++;
      end
      if (config_mode === 1'b1 && wht_in_ready !== 1'b1) begin
        r_bub++;
        tests++;
        if (r_wr == 0 || r_wr % 9 != 0) begin
          fails++; $display("FAIL bubble_pos: got bubble after %0d writes want multiple of 9", r_wr);
        end
      end
      if (next_kernel === 1'b1) nk_at.push_back(r_iss);
      if (stall_left > 0) begin
        if (ce_execute !== 1'b0) r_gap = r_gap + 100;
        else r_gap++;
        tests++;
        if (ce_execute !== 1'b0 || wht_seq_addr0 !== 4'd2 || wht_seq_addr1 !== 4'd3) begin
          fails++; $display("FAIL stall_hold: got exe=%0b a0=%0d a1=%0d want 0/2/3",
                            ce_execute, wht_seq_addr0, wht_seq_addr1);
        end
        stall_left--;
        if (stall_left == 0) ce_stall = 1'b0;
      end
      if (ce_execute === 1'b1) begin
        c  = r_iss % 5;
        e0 = (c < 4) ? 2 * c : 8;
        e1 = (c < 4) ? 2 * c + 1 : 9;
        tests++;
        if (ce_cycle_counter !== 3'(c) || wht_seq_addr0 !== 4'(e0) || wht_seq_addr1 !== 4'(e1)) begin
          fails++; $display("FAIL issue_%0d: got c=%0d a=(%0d,%0d) want c=%0d a=(%0d,%0d)", r_iss,
                            ce_cycle_counter, wht_seq_addr0, wht_seq_addr1, c, e0, e1);
        end
        r_iss++;
        last_iss_cyc = cyc;
        if (do_stall && !stalled && c == 1) begin
          ce_stall = 1'b1; stall_left = 4; stalled = 1;
        end
      end
      if (job_done === 1'b1) done_cyc = cyc;
      wht_in_valid = rnd_valid ? 1'($urandom) : 1'b1;
      wht_in_data  = 16'($urandom);
      if (poke && ((!poked_cfg && config_mode === 1'b1 && cyc == 2) ||
                   (!poked_exec && ce_execute === 1'b1 && r_iss == 2))) begin
        if (cyc == 2) poked_cfg = 1; else poked_exec = 1;
        job_start = 1'b1; job_kernel_last = 16'(k + 5);
        #1;
        tests++;
        if (job_accept !== 1'b0 || kernel_config_valid !== 1'b0) begin
          fails++; $display("FAIL busy_start: got accept=%0b want 0", job_accept);
        end
      end
      if (wht_in_ready === 1'b1 && wht_in_valid === 1'b1) exp_q.push_back(wht_in_data);
    end
    left_q = exp_q.size();
    job_start = 1'b0; wht_in_valid = 1'b0;
  endtask

  // Shared end-of-job checks against the spec's counting rules.
  task automatic check_job(input string tag, input int k, input int pix);
    int ppix;
    ppix = (pix == 0) ? 1 : pix;
    tests++;
    if (done_cyc < 0) begin
      fails++; $display("FAIL %s_timeout: got no job_done want job_done", tag);
    end else if (done_cyc - last_iss_cyc != 6) begin
      fails++; $display("FAIL %s_drain: got %0d want 6", tag, done_cyc - last_iss_cyc);
    end
    tests++;
    if (r_wr != 9 * (k + 1) || r_bub != k + 1 || left_q != 0) begin
      fails++; $display("FAIL %s_cfg: got wr=%0d bub=%0d pend=%0d want wr=%0d bub=%0d pend=0",
                        tag, r_wr, r_bub, left_q, 9 * (k + 1), k + 1);
    end
    tests++;
    if (r_iss != 5 * (k + 1) * ppix) begin
      fails++; $display("FAIL %s_issues: got %0d want %0d", tag, r_iss, 5 * (k + 1) * ppix);
    end
    tests++;
    if (nk_at.size() != k) begin
      fails++; $display("FAIL %s_nk_count: got %0d want %0d", tag, nk_at.size(), k);
    end else begin
      foreach (nk_at[j]) begin
        if (nk_at[j] != 5 * ppix * (j + 1)) begin
          fails++; $display("FAIL %s_nk_pos: got %0d want %0d", tag, nk_at[j], 5 * ppix * (j + 1));
        end
      end
    end
    @(negedge clk);
    tests++;
    if (job_done !== 1'b0 || config_mode !== 1'b0 || kernel_full_count !== 16'(k)) begin
      fails++; $display("FAIL %s_end: got done=%0b cm=%0b kfc=%0d want 0/0/%0d",
                        tag, job_done, config_mode, kernel_full_count, k);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (all_outs() !== 64'd0) begin
      fails++; $display("FAIL reset_outs: got %0h want 0", all_outs());
    end
    rst = 1'b0;
  endtask

  task automatic test_single_kernel();
    run_job(0, 1, 1'b0, 1'b0, 1'b0);
    check_job("single", 0, 1);
  endtask

  task automatic test_multi_kernel();
    run_job(2, 3, 1'b1, 1'b0, 1'b0);
    check_job("multi", 2, 3);
  endtask

  task automatic test_stall();
    run_job(0, 2, 1'b0, 1'b1, 1'b0);
    check_job("stall", 0, 2);
    tests++;
    if (r_gap != 4) begin
      fails++; $display("FAIL stall_gap: got %0d want 4", r_gap);
    end
  endtask

  task automatic test_start_ignored();
    run_job(1, 1, 1'b1, 1'b0, 1'b1);
    check_job("busy", 1, 1);
  endtask

  task automatic test_zero_pix();
    run_job(0, 0, 1'b0, 1'b0, 1'b0);
    check_job("zeropix", 0, 0);
  endtask

  task automatic test_reset_mid_exec();
    int seen, saw_done;
    seen = 0; saw_done = 0;
    @(negedge clk);
    job_kernel_last = 16'd1; job_pix_count = 16'd2; job_start = 1'b1; wht_in_valid = 1'b1;
    for (int cyc = 0; cyc < 500 && seen < 3; cyc++) begin
      @(negedge clk);
      job_start = 1'b0;
      if (ce_execute === 1'b1) seen++;
    end
    tests++;
    if (seen < 3) begin
      fails++; $display("FAIL midrst_reach: got %0d issues want 3", seen);
    end
    wht_in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (all_outs() !== 64'd0) begin
      fails++; $display("FAIL midrst_outs: got %0h want 0", all_outs());
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (job_done === 1'b1 || ce_execute === 1'b1 || config_mode === 1'b1) saw_done = 1;
    end
    tests++;
    if (saw_done != 0) begin
      fails++; $display("FAIL midrst_idle: got activity=%0d want 0", saw_done);
    end
  endtask

  task automatic test_back_to_back();
    int k, p;
    for (int j = 0; j < 3; j++) begin
      k = int'($urandom_range(0, 3));
      p = int'($urandom_range(0, 3));
      run_job(k, p, 1'($urandom), 1'b0, 1'b0);
      check_job("b2b", k, p);
    end
  endtask

  initial begin
    test_reset();
    test_single_kernel();
    test_multi_kernel();
    test_stall();
    test_start_ignored();
    test_zero_pix();
    test_reset_mid_exec();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
